// File: rtl/pulse_period_meter.sv
// pulse_period_meter: synchronises a pulse train and measures period and high time in clk cycles.
module pulse_period_meter #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             signal_in,
   input  logic             enable,
   input  logic             clear,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             valid,
   output logic             overflow,
   output logic [7:0]       edge_count
);
   typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;
   localparam logic [WIDTH-1:0] MAX = '1;
   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic                   r_fell;
   logic [WIDTH-1:0]       r_cnt;
   logic [WIDTH-1:0]       r_hcnt;
   logic                   w_sync_out;
   logic                   w_rise;
   assign w_sync_out = r_sync[SYNC_STAGES-1];
   assign w_rise     = w_sync_out & ~r_hist;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in};
         r_hist <= w_sync_out;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state    <= IDLE;
         r_fell     <= 1'b0;
         r_cnt      <= '0;
         r_hcnt     <= '0;
         period     <= '0;
         high_time  <= '0;
         valid      <= 1'b0;
         overflow   <= 1'b0;
         edge_count <= '0;
      end else begin
         valid <= 1'b0;
         if (clear) begin
            r_state    <= IDLE;
            r_fell     <= 1'b0;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            overflow   <= 1'b0;
            edge_count <= '0;
         end else if (!enable) begin
            r_state <= IDLE;
         end else if (w_rise) begin
            if (r_state == MEASURE) begin
               period    <= r_cnt;
               high_time <= r_hcnt;
               valid     <= 1'b1;
            end
            r_cnt      <= WIDTH'(1);
            r_hcnt     <= WIDTH'(1);
            r_fell     <= 1'b0;
            edge_count <= edge_count + 8'd1;
            r_state    <= MEASURE;
         end else if (r_state == MEASURE) begin
            // high time stops at the first fall; later high cycles in the period are ignored
            if (r_cnt == MAX) begin
               overflow <= 1'b1;
               r_state  <= STALLED;
            end else begin
               r_cnt  <= r_cnt + WIDTH'(1);
               r_fell <= r_fell | ~w_sync_out;
               if (w_sync_out && !r_fell && r_hcnt != MAX) r_hcnt <= r_hcnt + WIDTH'(1);
            end
         end
      end
endmodule
